// File: rtl/nibble_serial_sub.sv
// Serial 6502-style subtractor: one 4-bit nibble per clock, LSB first, with N/V/Z/C flags.
// Optional BCD correction is compiled in when NIBBLE_SUB_DECIMAL_EN is defined.
module nibble_serial_sub #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   decimal,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   cout,
    output logic                   n_flag,
    output logic                   v_flag,
    output logic                   z_flag
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               cout_q, cout_d;
    logic               v_q, v_d;
    logic               n_q, n_d;
    logic               z_q, z_d;
`ifdef NIBBLE_SUB_DECIMAL_EN
    logic               dec_q, dec_d;
`else
    logic               unused_decimal;
    assign unused_decimal = decimal;
`endif

    logic [4:0]         sum;
    logic [3:0]         low3;
    logic [3:0]         nib;
    logic               accept;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        diff_d  = diff_q;
        cout_d  = cout_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
`ifdef NIBBLE_SUB_DECIMAL_EN
        dec_d   = dec_q;
`endif

        // Operands are shifted down each cycle, so the active nibble is always [3:0].
        sum  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0, carry_q};
        low3 = {1'b0, a_q[2:0]} + {1'b0, ~b_q[2:0]} + {3'b0, carry_q};
        nib  = sum[3:0];
`ifdef NIBBLE_SUB_DECIMAL_EN
        if (dec_q && !sum[4]) begin
            nib = sum[3:0] - 4'd6;
        end
`endif

        accept = start && (state_q != CALC);

        case (state_q)
            IDLE: state_d = IDLE;
            CALC: begin
                carry_d = sum[4];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[4*i +: 4] = nib;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // Flags are captured from the final diff so they are valid during DONE.
                    cout_d  = sum[4];
                    v_d     = low3[3] ^ sum[4];
                    n_d     = diff_d[W-1];
                    z_d     = (diff_d == '0);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
`ifdef NIBBLE_SUB_DECIMAL_EN
            dec_d   = decimal;
`endif
            state_d = CALC;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            diff_q  <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
`ifdef NIBBLE_SUB_DECIMAL_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            diff_q  <= diff_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
`ifdef NIBBLE_SUB_DECIMAL_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign cout   = cout_q;
    assign n_flag = n_q;
    assign v_flag = v_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed self-checking bench for nibble_serial_sub with NIBBLES=2.
// Expected decimal results follow NIBBLE_SUB_DECIMAL_EN when it is defined for the build.
module tb_nibble_serial_sub;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       decimal;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       cout;
    logic       n_flag;
    logic       v_flag;
    logic       z_flag;

    int tests_run    = 0;
    int tests_failed = 0;

    nibble_serial_sub #(.NIBBLES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .decimal (decimal),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .cout    (cout),
        .n_flag  (n_flag),
        .v_flag  (v_flag),
        .z_flag  (z_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulses start for one cycle and waits (bounded) for done; lat = -1 on timeout.
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         input logic di, output int lat, output logic [7:0] d_o,
                         output logic [3:0] f_o);
        @(negedge clk);
        a = ai; b = bi; cin = ci; decimal = di; start = 1'b1;
        lat = -1;
        d_o = 8'h00;
        f_o = 4'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                d_o = diff;
                f_o = {cout, v_flag, n_flag, z_flag};
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; a = 8'h50; b = 8'h20; cin = 1'b1; decimal = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, diff, cout, n_flag, v_flag, z_flag} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h c=%b n=%b v=%b z=%b, want all 0",
                     busy, done, diff, cout, n_flag, v_flag, z_flag);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_binary();
        logic [7:0] va[6] = '{8'h50, 8'h50, 8'h00, 8'h42, 8'h42, 8'h80};
        logic [7:0] vb[6] = '{8'h20, 8'hB0, 8'h01, 8'h42, 8'h42, 8'h01};
        logic       vc[6] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [7:0] ed[6] = '{8'h30, 8'hA0, 8'hFF, 8'h00, 8'hFF, 8'h7F};
        // {cout, v, n, z}
        logic [3:0] ef[6] = '{4'b1000, 4'b0110, 4'b0010, 4'b1001, 4'b0010, 4'b1100};
        int         lat;
        logic [7:0] d;
        logic [3:0] f;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, lat, d, f);
            tests_run++;
            if (lat !== 3) begin
                tests_failed++;
                $display("FAIL binary_latency[%0d]: got %0d cycles, want 3", i, lat);
            end
            tests_run++;
            if ({d, f} !== {ed[i], ef[i]}) begin
                tests_failed++;
                $display("FAIL binary_result[%0d] %h-%h cin=%b: got diff=%h cvnz=%b, want diff=%h cvnz=%b",
                         i, va[i], vb[i], vc[i], d, f, ed[i], ef[i]);
            end
        end
    endtask

    task automatic test_decimal();
        int         lat;
        logic [7:0] d;
        logic [3:0] f;
`ifdef NIBBLE_SUB_DECIMAL_EN
        logic [7:0] e1 = 8'h29;
        logic [7:0] e2 = 8'h90;
`else
        logic [7:0] e1 = 8'h2F;
        logic [7:0] e2 = 8'hF0;
`endif
        do_op(8'h42, 8'h13, 1'b1, 1'b1, lat, d, f);
        tests_run++;
        if ({d, f} !== {e1, 4'b1000}) begin
            tests_failed++;
            $display("FAIL decimal_42_13: got diff=%h cvnz=%b, want diff=%h cvnz=1000", d, f, e1);
        end
        do_op(8'h10, 8'h20, 1'b1, 1'b1, lat, d, f);
        tests_run++;
        if ({d, f} !== {e2, 4'b0010}) begin
            tests_failed++;
            $display("FAIL decimal_10_20: got diff=%h cvnz=%b, want diff=%h cvnz=0010", d, f, e2);
        end
        do_op(8'h42, 8'h13, 1'b1, 1'b0, lat, d, f);
        tests_run++;
        if (d !== 8'h2F) begin
            tests_failed++;
            $display("FAIL decimal_off_42_13: got diff=%h, want 2f", d);
        end
    endtask

    task automatic test_back_to_back();
        // start held high: CALC,CALC,DONE repeating, each done accepting the next op
        logic [1:0] exp_bd[6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        @(negedge clk);
        a = 8'h50; b = 8'h20; cin = 1'b1; decimal = 1'b0; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, done} !== exp_bd[i]) begin
                tests_failed++;
                $display("FAIL b2b_handshake[%0d]: got busy,done=%b, want %b", i, {busy, done}, exp_bd[i]);
            end
            if (i == 2) begin
                tests_run++;
                if ({diff, cout} !== {8'h30, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL b2b_first: got diff=%h c=%b, want 30 1", diff, cout);
                end
                a = 8'h00; b = 8'h01;
            end
            if (i == 5) begin
                tests_run++;
                if ({diff, cout, n_flag} !== {8'hFF, 1'b0, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL b2b_second: got diff=%h c=%b n=%b, want ff 0 1", diff, cout, n_flag);
                end
                start = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_idle: got busy,done=%b, want 00", {busy, done});
        end
    endtask

    task automatic test_start_mid_calc();
        @(negedge clk);
        a = 8'h50; b = 8'h20; cin = 1'b1; decimal = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h00; b = 8'hFF; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({done, diff, cout, z_flag} !== {1'b1, 8'h30, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_calc_result: got done=%b diff=%h c=%b z=%b, want 1 30 1 0",
                     done, diff, cout, z_flag);
        end
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_calc_ignored: got busy,done=%b, want 00", {busy, done});
        end
    endtask

    task automatic test_reset_mid_op();
        int         lat;
        logic [7:0] d;
        logic [3:0] f;
        logic       saw_done = 1'b0;
        @(negedge clk);
        a = 8'h50; b = 8'h20; cin = 1'b1; decimal = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, diff, cout, n_flag, v_flag, z_flag} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b diff=%h c=%b n=%b v=%b z=%b, want all 0",
                     busy, done, diff, cout, n_flag, v_flag, z_flag);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_done: got done pulse=%b, want 0", saw_done);
        end
        do_op(8'h42, 8'h13, 1'b1, 1'b0, lat, d, f);
        tests_run++;
        if ({lat, d, f} !== {32'd3, 8'h2F, 4'b1000}) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: got lat=%0d diff=%h cvnz=%b, want 3 2f 1000", lat, d, f);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; decimal = 1'b0;
        test_reset();
        test_binary();
        test_decimal();
        test_back_to_back();
        test_start_mid_calc();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle subtractor for the m6502 datapath models; the subtract-side counterpart to the nibble adder slices.
- Computes a - b - (1 - cin) with 6502 SBC carry semantics: cin=1 means no borrow, cout=1 means no borrow occurred.
- Processes one 4-bit nibble per clock, LSB nibble first, and returns the result plus N/V/Z/C flags with a start/done handshake.

Parameters:
- NIBBLES, 2, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  W  minuend; latched when start is accepted
- b  input  W  subtrahend; latched when start is accepted
- cin  input  1  carry in (1 = no borrow); latched when start is accepted
- decimal  input  1  BCD mode request; latched when start is accepted; see Optional Feature
- busy  output  1  high while nibbles are being computed
- done  output  1  one-cycle pulse; result and flags valid
- diff  output  W  result
- cout  output  1  C flag (1 = no borrow)
- n_flag  output  1  diff[W-1]
- v_flag  output  1  signed overflow of the binary subtraction
- z_flag  output  1  diff == 0

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - reset is synchronous and active-high.
  - Reset puts the FSM in IDLE and forces busy=0, done=0, diff=0, cout=0, n_flag=0, v_flag=0, z_flag=0.
  - Reset wins over start in the same cycle.
  - Reset during CALC abandons the operation; no done pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1, latch a, b, cin and decimal; set idx=0 and carry=cin; go to CALC.
- CALC (busy=1):
  - Each cycle: d = a_nib[idx] + ~b_nib[idx] + carry, 5 bits wide.
  - carry <= d[4]; the nibble result is d[3:0], subject to decimal correction.
  - The result nibble is written into diff[4*idx+3:4*idx]; idx increments.
  - At idx = NIBBLES-1: also compute v = (carry into bit W-1) XOR (carry out of bit W-1) from the uncorrected sum; go to DONE.
  - start is ignored in CALC.
- DONE (done=1, busy=0, one cycle):
  - cout = final carry; v_flag = v.
  - n_flag and z_flag come from the final stored diff.
  - If start=1 in DONE, accept it and go to CALC; otherwise go to IDLE.
- Latency and holding:
  - Start accepted at edge k; done is high in the cycle after edge k+NIBBLES.
  - Back-to-back throughput is one operation per NIBBLES+1 cycles.
- diff and all flags hold their values until the next accepted start. They may update nibble by nibble during CALC; only the done cycle guarantees validity.
- No registered value depends on the a/b/cin/decimal inputs after acceptance; input changes during CALC have no effect.

Optional Feature:
- Macro: NIBBLE_SUB_DECIMAL_EN.
- Defined:
  - If latched decimal=1 and the nibble carry d[4]=0, the nibble result is (d[3:0] - 6) mod 16.
  - carry, cout and v_flag are always taken from the binary path.
  - n_flag and z_flag reflect the corrected diff.
  - Non-BCD operands give defined but unspecified digit values; there is no error flag.
- Undefined: the decimal input is ignored and all operations are binary.

Test Plan:
- Binary basic: NIBBLES=2, a=0x50, b=0x20, cin=1 -> diff=0x30, cout=1, v=0, n=0, z=0; done exactly 3 cycles after start is sampled.
- Overflow and borrow: a=0x50, b=0xB0, cin=1 -> diff=0xA0, cout=0, v=1, n=1; and a=0x00, b=0x01, cin=1 -> diff=0xFF, cout=0, v=0, n=1.
- Zero and borrow-in: a=0x42, b=0x42, cin=1 -> diff=0x00, z=1, cout=1; same operands with cin=0 -> diff=0xFF, cout=0, z=0.
- Decimal (macro defined, decimal=1): 0x42-0x13 with cin=1 -> 0x29, cout=1; 0x10-0x20 with cin=1 -> 0x90, cout=0. With the macro undefined, 0x42-0x13 -> 0x2F.
- Handshake: start held high throughout -> accepted only in IDLE/DONE; a second start pulse mid-CALC is ignored; back-to-back operations complete every 3 cycles with single-cycle done pulses.
- Reset mid-operation: assert reset on the second CALC cycle -> next cycle busy=0, done=0, all outputs 0, and no done pulse follows; a subsequent start computes correctly.
